// File: rtl/hilo_mult_ctrl.sv
// hilo_mult_ctrl: owns the architectural HI/LO pair and sequences MULT/MULTU
// through the shared ALU multiplier as a low-half op followed by a high-half op.
// The high-half op reuses the multiplier's operand cache, so it finishes one
// cycle after the low half. MTHI/MTLO writes are accepted in every state.

`ifndef ALU_OPCODE_WIDTH
`define ALU_OPCODE_WIDTH 6
`endif
`ifndef ALU_MULTL
`define ALU_MULTL 24
`endif
`ifndef ALU_MULTH
`define ALU_MULTH 25
`endif
`ifndef ALU_MULTLU
`define ALU_MULTLU 26
`endif
`ifndef ALU_MULTHU
`define ALU_MULTHU 27
`endif

module hilo_mult_ctrl #(
    parameter int OPW = `ALU_OPCODE_WIDTH
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            req_valid,
    input  logic            req_signed,
    input  logic [31:0]     req_src1,
    input  logic [31:0]     req_src2,
    output logic            req_ready,
    input  logic            wr_hi,
    input  logic            wr_lo,
    input  logic [31:0]     wr_data,
    output logic [31:0]     hi,
    output logic [31:0]     lo,
    output logic            busy,
    output logic [OPW-1:0]  mul_opcode,
    output logic [31:0]     mul_src1,
    output logic [31:0]     mul_src2,
    input  logic [31:0]     mul_result,
    input  logic            mul_done,
    input  logic            mul_busy
);

    localparam logic [OPW-1:0] OP_MULTL  = OPW'(`ALU_MULTL);
    localparam logic [OPW-1:0] OP_MULTH  = OPW'(`ALU_MULTH);
    localparam logic [OPW-1:0] OP_MULTLU = OPW'(`ALU_MULTLU);
    localparam logic [OPW-1:0] OP_MULTHU = OPW'(`ALU_MULTHU);

    typedef enum logic [2:0] {
        INIT_ISSUE,
        INIT_WAIT,
        IDLE,
        LO_WAIT,
        HI_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_src1;
    logic [31:0] r_src2;
    logic        r_signed;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_pend_hi;
    logic        r_pend_lo;
    logic        w_accept;
    logic        w_cap_lo;
    logic        w_cap_hi;

    // State register; reset restarts the cache-priming sequence
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= INIT_ISSUE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, multiplier opcode and capture/accept strobes
    always_comb begin
        w_next     = r_state;
        mul_opcode = '0;
        w_accept   = 1'b0;
        w_cap_lo   = 1'b0;
        w_cap_hi   = 1'b0;
        case (r_state)
            INIT_ISSUE: begin
                // 1x1 unsigned evicts whatever the cache held, so 0x0 cannot hit stale data
                mul_opcode = OP_MULTLU;
                w_next     = INIT_WAIT;
            end
            INIT_WAIT: begin
                if (mul_done) begin
                    w_next = IDLE;
                end
            end
            IDLE: begin
                if (req_valid) begin
                    w_accept   = 1'b1;
                    mul_opcode = req_signed ? OP_MULTL : OP_MULTLU;
                    w_next     = LO_WAIT;
                end
            end
            LO_WAIT: begin
                if (mul_done) begin
                    w_cap_lo   = 1'b1;
                    mul_opcode = r_signed ? OP_MULTH : OP_MULTHU;
                    w_next     = HI_WAIT;
                end
            end
            HI_WAIT: begin
                if (mul_done) begin
                    w_cap_hi = 1'b1;
                    w_next   = IDLE;
                end
            end
            default: begin
                w_next = INIT_ISSUE;
            end
        endcase
    end

    // Operand/sign latch; reset value doubles as the cache-priming operands
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_src1   <= 32'd1;
            r_src2   <= 32'd1;
            r_signed <= 1'b0;
        end else if (w_accept) begin
            r_src1   <= req_src1;
            r_src2   <= req_src2;
            r_signed <= req_signed;
        end
    end

    // HI/LO update: MTHI/MTLO override a same-cycle capture, but an accept re-arms pend
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 1'b0;
            r_pend_lo <= 1'b0;
        end else begin
            if (w_cap_lo && r_pend_lo) begin
                r_lo <= mul_result;
            end
            if (w_cap_hi && r_pend_hi) begin
                r_hi <= mul_result;
            end
            if (wr_lo) begin
                r_lo      <= wr_data;
                r_pend_lo <= 1'b0;
            end
            if (wr_hi) begin
                r_hi      <= wr_data;
                r_pend_hi <= 1'b0;
            end
            if (w_accept) begin
                r_pend_lo <= 1'b1;
                r_pend_hi <= 1'b1;
            end
        end
    end

    assign mul_src1  = (r_state == IDLE) ? req_src1 : r_src1;
    assign mul_src2  = (r_state == IDLE) ? req_src2 : r_src2;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign busy      = (r_state != IDLE);
    assign req_ready = (r_state == IDLE);

    a_no_done_in_idle: assert property (@(posedge CLK) disable iff (RST)
        !((r_state == IDLE) && mul_done));

    a_no_mul_busy_in_idle: assert property (@(posedge CLK) disable iff (RST)
        !((r_state == IDLE) && mul_busy));

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Bench for hilo_mult_ctrl: a behavioural multiplier with a one-entry operand
// cache (miss = 2 cycles, hit = 1 cycle) sits behind the DUT; expected HI/LO and
// latencies come from plain 64-bit products and the cache-hit rule.

`ifndef ALU_OPCODE_WIDTH
`define ALU_OPCODE_WIDTH 6
`endif
`ifndef ALU_MULTL
`define ALU_MULTL 24
`endif
`ifndef ALU_MULTH
`define ALU_MULTH 25
`endif
`ifndef ALU_MULTLU
`define ALU_MULTLU 26
`endif
`ifndef ALU_MULTHU
`define ALU_MULTHU 27
`endif

module tb_hilo_mult_ctrl;

    localparam int OPW = `ALU_OPCODE_WIDTH;
    localparam logic [OPW-1:0] OP_L  = OPW'(`ALU_MULTL);
    localparam logic [OPW-1:0] OP_H  = OPW'(`ALU_MULTH);
    localparam logic [OPW-1:0] OP_LU = OPW'(`ALU_MULTLU);
    localparam logic [OPW-1:0] OP_HU = OPW'(`ALU_MULTHU);

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_signed = 1'b0;
    logic [31:0]     req_src1 = '0;
    logic [31:0]     req_src2 = '0;
    logic            req_ready;
    logic            wr_hi = 1'b0;
    logic            wr_lo = 1'b0;
    logic [31:0]     wr_data = '0;
    logic [31:0]     hi;
    logic [31:0]     lo;
    logic            busy;
    logic [OPW-1:0]  mul_opcode;
    logic [31:0]     mul_src1;
    logic [31:0]     mul_src2;
    logic [31:0]     mul_result;
    logic            mul_done;
    logic            mul_busy;

    hilo_mult_ctrl #(.OPW(OPW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_signed (req_signed),
        .req_src1   (req_src1),
        .req_src2   (req_src2),
        .req_ready  (req_ready),
        .wr_hi      (wr_hi),
        .wr_lo      (wr_lo),
        .wr_data    (wr_data),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .mul_opcode (mul_opcode),
        .mul_src1   (mul_src1),
        .mul_src2   (mul_src2),
        .mul_result (mul_result),
        .mul_done   (mul_done),
        .mul_busy   (mul_busy)
    );

    always #5 CLK = ~CLK;

    // ---------------- multiplier model with one-entry operand cache ----------------
    logic [31:0] c_s1, c_s2, m_held, m_half;
    logic        c_sgn, m_pend, op_sgn, op_hi, m_hit;
    logic [63:0] m_prod;

    always_comb begin
        op_sgn = (mul_opcode == OP_L) || (mul_opcode == OP_H);
        op_hi  = (mul_opcode == OP_H) || (mul_opcode == OP_HU);
        if (op_sgn)
            m_prod = longint'($signed(mul_src1)) * longint'($signed(mul_src2));
        else
            m_prod = {32'b0, mul_src1} * {32'b0, mul_src2};
        m_half = op_hi ? m_prod[63:32] : m_prod[31:0];
        m_hit  = (mul_src1 == c_s1) && (mul_src2 == c_s2) && (op_sgn == c_sgn);
    end

    always @(posedge CLK) begin
        if (RST) begin
            c_s1       <= '0;
            c_s2       <= '0;
            c_sgn      <= 1'b0;
            m_pend     <= 1'b0;
            m_held     <= '0;
            mul_done   <= 1'b0;
            mul_busy   <= 1'b0;
            mul_result <= '0;
        end else begin
            mul_done <= 1'b0;
            mul_busy <= 1'b0;
            if (m_pend) begin
                mul_done   <= 1'b1;
                mul_result <= m_held;
                m_pend     <= 1'b0;
            end
            if (mul_opcode != '0) begin
                c_s1  <= mul_src1;
                c_s2  <= mul_src2;
                c_sgn <= op_sgn;
                if (m_hit) begin
                    mul_done   <= 1'b1;
                    mul_result <= m_half;
                end else begin
                    m_pend   <= 1'b1;
                    m_held   <= m_half;
                    mul_busy <= 1'b1;
                end
            end
        end
    end

    // ---------------- reference state and checking ----------------
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] ref_hi, ref_lo, last_a, last_b;
    bit          last_s;
    logic [31:0] edge_v [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Hold RST over one edge, release, then verify the priming sequence
    task automatic do_reset();
        int n;
        RST = 1'b1;
        req_valid = 1'b0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_opcode", 64'(mul_opcode), 64'(OP_LU));
        chk("rst_src1", 64'(mul_src1), 64'd1);
        chk("rst_src2", 64'(mul_src2), 64'd1);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge CLK);
            n++;
        end
        chk("init_ready_cycle", 64'(n), 64'd3);
        ref_hi = '0;
        ref_lo = '0;
        last_a = 32'd1;
        last_b = 32'd1;
        last_s = 1'b0;
    endtask

    // One multiply; klo/khi = cycle offset of a wr_lo/wr_hi strobe (-1 = none)
    task automatic run_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input int klo, input int khi, input logic [31:0] wd);
        logic [63:0] prod;
        logic [31:0] exp_lo, exp_hi, mid_lo;
        bit          hit;
        int          lat, lodone, n, k;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("ready_before_req", 64'(req_ready), 64'd1);
        if (sgn)
            prod = longint'($signed(a)) * longint'($signed(b));
        else
            prod = {32'b0, a} * {32'b0, b};
        hit    = (a == last_a) && (b == last_b) && (sgn == last_s);
        lat    = hit ? 3 : 4;
        lodone = hit ? 1 : 2;
        exp_lo = (klo >= 1 && klo < lat) ? wd : prod[31:0];
        exp_hi = (khi >= 1 && khi < lat) ? wd : prod[63:32];
        mid_lo = (klo >= 1 && klo <= lodone) ? wd : prod[31:0];

        req_valid  = 1'b1;
        req_signed = sgn;
        req_src1   = a;
        req_src2   = b;
        wr_data    = wd;
        wr_lo      = (klo == 0);
        wr_hi      = (khi == 0);
        #1;
        chk("issue_low_op", 64'(mul_opcode), 64'(sgn ? OP_L : OP_LU));
        chk("issue_low_src1", 64'(mul_src1), 64'(a));
        chk("issue_low_src2", 64'(mul_src2), 64'(b));

        k = 0;
        while (k < 8) begin
            @(negedge CLK);
            k++;
            req_valid = 1'b0;
            wr_lo = 1'b0;
            wr_hi = 1'b0;
            #1;
            if (req_ready) break;
            chk("busy_in_flight", 64'(busy), 64'd1);
            if (k == lodone) begin
                chk("issue_high_op", 64'(mul_opcode), 64'(sgn ? OP_H : OP_HU));
                chk("issue_high_src1", 64'(mul_src1), 64'(a));
                chk("issue_high_src2", 64'(mul_src2), 64'(b));
            end
            if (k == lodone + 1)
                chk("lo_after_low_half", 64'(lo), 64'(mid_lo));
            wr_lo = (klo == k);
            wr_hi = (khi == k);
        end
        wr_lo = 1'b0;
        wr_hi = 1'b0;
        chk("ready_latency", 64'(k), 64'(lat));
        chk("final_lo", 64'(lo), 64'(exp_lo));
        chk("final_hi", 64'(hi), 64'(exp_hi));
        ref_lo = exp_lo;
        ref_hi = exp_hi;
        last_a = a;
        last_b = b;
        last_s = sgn;
    endtask

    // MTHI/MTLO while idle
    task automatic idle_write(input bit to_hi, input logic [31:0] d);
        wr_hi   = to_hi;
        wr_lo   = !to_hi;
        wr_data = d;
        @(negedge CLK);
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        if (to_hi) ref_hi = d;
        else       ref_lo = d;
        chk("idle_wr_hi", 64'(hi), 64'(ref_hi));
        chk("idle_wr_lo", 64'(lo), 64'(ref_lo));
    endtask

    // Reset two cycles into a miss, before the low half can land
    task automatic rst_mid();
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("rst_mid_ready", 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_signed = 1'b0;
        req_src1   = 32'h10;
        req_src2   = 32'h20;
        @(negedge CLK);
        req_valid = 1'b0;
        @(negedge CLK);
        chk("rst_mid_busy", 64'(busy), 64'd1);
        chk("rst_mid_lo_before", 64'(lo), 64'(ref_lo));
        do_reset();
    endtask

    initial begin
        bit          s;
        int          sel, klo, khi;
        logic [31:0] a, b;
        do_reset();

        run_mul(1'b0, 32'h0, 32'h0, -1, -1, 32'h0);
        run_mul(1'b1, 32'h3, 32'hFFFF_FFFE, -1, -1, 32'h0);
        run_mul(1'b0, 32'h3, 32'hFFFF_FFFE, -1, -1, 32'h0);
        run_mul(1'b0, 32'h3, 32'hFFFF_FFFE, -1, -1, 32'h0);
        run_mul(1'b1, 32'h5, 32'h7, 1, -1, 32'h1234_5678);
        run_mul(1'b1, 32'h5, 32'h7, -1, 2, 32'hCAFE_F00D);
        run_mul(1'b1, 32'h9, 32'hB, 0, 0, 32'h5555_AAAA);
        idle_write(1'b1, 32'hDEAD_BEEF);
        idle_write(1'b0, 32'h0BAD_F00D);

        rst_mid();
        run_mul(1'b0, 32'h2, 32'h3, -1, -1, 32'h0);

        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 3));
            s   = 1'($urandom_range(0, 1));
            case (sel)
                0: begin
                    a = last_a;
                    b = last_b;
                    if ($urandom_range(0, 1) == 1) s = last_s;
                end
                1: begin
                    a = 32'($urandom_range(0, 15));
                    b = 32'($urandom_range(0, 15));
                end
                2: begin
                    a = $urandom;
                    b = $urandom;
                end
                default: begin
                    a = edge_v[$urandom_range(0, 3)];
                    b = edge_v[$urandom_range(0, 3)];
                end
            endcase
            klo = int'($urandom_range(0, 4)) - 1;
            khi = int'($urandom_range(0, 4)) - 1;
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            if ($urandom_range(0, 3) == 0)
                idle_write(1'($urandom_range(0, 1)), $urandom);
            run_mul(s, a, b, klo, khi, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
